// File: rtl/aes_pkg.sv
// Shared types, sizes and byte-level transforms for the iterative AES-128 encryptor.
// The FIPS-197 byte order is used throughout: input byte 0 is bits [127:120].
// In the packed aes_blk_t, byte n sits at index 15-n.
// Column c of the AES state holds bytes 4c..4c+3.
package aes_pkg;

  localparam int unsigned NR        = 10;
  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned RK_IDX_W  = 4;
  localparam int unsigned NB_BYTES  = AES_BLK_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  typedef logic [NB_BYTES-1:0][7:0] aes_blk_t;

  // Forward S-box.  Entry 0 is in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Single S-box lookup
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'(2040 - 8 * int'(b)) +: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes: S-box applied to every byte
  function automatic aes_blk_t sub_bytes(input aes_blk_t s);
    aes_blk_t r;
    for (int n = 0; n < 16; n++) begin
      r[4'(n)] = sbox(s[4'(n)]);
    end
    return r;
  endfunction

  // ShiftRows: row r rotates left by r columns
  function automatic aes_blk_t shift_rows(input aes_blk_t s);
    aes_blk_t r;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[4'(15 - (row + 4 * col))] = s[4'(15 - (row + 4 * ((col + row) % 4)))];
      end
    end
    return r;
  endfunction

  // MixColumns: each column multiplied by the fixed {02,03,01,01} circulant
  function automatic aes_blk_t mix_columns(input aes_blk_t s);
    aes_blk_t   r;
    logic [7:0] a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[4'(15 - 4 * col)];
      a1 = s[4'(14 - 4 * col)];
      a2 = s[4'(13 - 4 * col)];
      a3 = s[4'(12 - 4 * col)];
      r[4'(15 - 4 * col)] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r[4'(14 - 4 * col)] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r[4'(13 - 4 * col)] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r[4'(12 - 4 * col)] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// final_rnd=1 bypasses MixColumns for the last round.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 final_rnd,
  output logic [AES_BLK_W-1:0] state_out
);

  aes_blk_t shifted;
  aes_blk_t mixed;

  // One full round of the cipher on the current state
  always_comb begin
    shifted   = shift_rows(sub_bytes(state_in));
    mixed     = final_rnd ? shifted : mix_columns(shifted);
    state_out = mixed ^ rk;
  end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per clock on a shared round
// datapath, round keys fetched by index from an external key store.
// Optional build macro AES_CTRL_ABORT_EN adds an abort input that drops the
// block in flight.
module aes_enc_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] plaintext,
  output logic [RK_IDX_W-1:0]  rk_idx,
  input  logic [AES_BLK_W-1:0] rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] ciphertext,
  output logic                 busy
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  aes_state_e            state_q, state_d;
  logic [RK_IDX_W-1:0]   rnd_q, rnd_d;
  logic [AES_BLK_W-1:0]  data_q, data_d;
  logic [AES_BLK_W-1:0]  round_out;
  logic                  final_rnd;
  logic                  abort_hit;
  logic                  in_ready_d, out_valid_d, busy_d;
  logic [RK_IDX_W-1:0]   rk_idx_d;

  // Abort only acts while a block is in flight or waiting for delivery
`ifdef AES_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign final_rnd  = (state_q == FINAL);
  assign ciphertext = data_q;

  aes_round_dp u_round_dp (
    .state_in  (data_q),
    .rk        (rk),
    .final_rnd (final_rnd),
    .state_out (round_out)
  );

  // Next-state, round counter and state register update
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = plaintext ^ rk;
          rnd_d   = RK_IDX_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = round_out;
        rnd_d  = rnd_q + RK_IDX_W'(1);
        if (rnd_q == RK_IDX_W'(NR - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        data_d  = round_out;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          rnd_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        rnd_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Abort drops the block but keeps the state register contents
    if (abort_hit) begin
      state_d = IDLE;
      rnd_d   = '0;
      data_d  = data_q;
    end
  end

  // Output values for the cycle after the coming edge, decoded from the next state
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ROUND) || (state_d == FINAL);
    rk_idx_d    = '0;
    unique case (state_d)
      ROUND:   rk_idx_d = rnd_d;
      FINAL:   rk_idx_d = RK_IDX_W'(NR);
      default: rk_idx_d = '0;
    endcase
  end

  // State, datapath register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      data_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rk_idx    <= '0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      data_q    <= data_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      rk_idx    <= rk_idx_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl: FIPS-197 vectors from a table, a key
// schedule model on rk, a ciphertext scoreboard, and hand-written sequences for
// backpressure, back-to-back blocks, mid-block reset and (AES_CTRL_ABORT_EN) abort.
module tb_aes_enc_ctrl;

  typedef struct {
    logic [127:0] pt;
    logic         sel;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, rk, ciphertext;
  logic [3:0]   rk_idx;
`ifdef AES_CTRL_ABORT_EN
  logic         abort;
`endif

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [7:0]   sb_tab [256];
  logic [127:0] ks [2][11];
  logic         pend_sel = 1'b0;
  logic         fly_sel = 1'b0;
  logic [127:0] exp_q [$];

  aes_enc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
`ifdef AES_CTRL_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store model: the waiting block's key while idle, else the in-flight block's key
  always_comb begin
    rk = '0;
    if (rk_idx <= 4'd10) rk = in_ready ? ks[pend_sel][rk_idx] : ks[fly_sel][rk_idx];
  end

  always @(posedge clk) if (in_valid && in_ready) fly_sel <= pend_sel;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int i = 1; i < 256; i++) if (gmul(8'(x), 8'(i)) == 8'h01) inv = 8'(i);
      sb_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // AES-128 key expansion into ks[sel][0..10]
  task automatic expand(input int sel, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[sel][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Present one block; expected ciphertext goes on the scoreboard at the accepting edge
  task automatic send(input logic [127:0] pt, input logic sel, input logic [127:0] exp,
                      output int acc, output logic [3:0] idx0, output logic busy0);
    bit ok = 1'b0;
    acc   = -1;
    idx0  = 4'hf;
    busy0 = 1'b1;
    plaintext = pt;
    pend_sel  = sel;
    in_valid  = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok    = 1'b1;
        idx0  = rk_idx;
        busy0 = busy;
      end
    end
    chk("accept", 128'(ok), 128'd1);
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(exp);
      #1;
      acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  // Follow a block from the accepting edge until out_valid, tracing rk_idx and busy
  task automatic wait_out(input logic [3:0] idx0, input logic busy0);
    logic [47:0] itr;
    logic [11:0] btr;
    int          n = 0;
    itr = {44'h0, idx0};
    btr = {11'h0, busy0};
    itr = {itr[43:0], rk_idx};
    btr = {btr[10:0], busy};
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      itr = {itr[43:0], rk_idx};
      btr = {btr[10:0], busy};
    end
    chk("latency", 128'(n), 128'd10);
    chk("rk_idx_seq", 128'(itr), 128'h0123456789a0);
    chk("busy_seq", 128'(btr), 128'h7fe);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && in_ready === 1'b1 && out_valid === 1'b0) ok = 1'b1;
    end
    chk("drain", 128'(ok), 128'd1);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({nm, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({nm, "_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic no_output(input string nm);
    bit seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk(nm, 128'(seen), 128'd0);
  endtask

  task automatic reach_round(input logic [3:0] r);
    bit seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (rk_idx === r && busy === 1'b1) seen = 1'b1;
    end
    chk("reach_round", 128'(seen), 128'd1);
  endtask

  // Scoreboard: compare whenever the coming edge completes an output handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1
`ifdef AES_CTRL_ABORT_EN
        && abort !== 1'b1
`endif
       ) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_without_block: ciphertext %h delivered with no block pending", ciphertext);
      end else begin
        chk("ciphertext", ciphertext, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [4];
    int         a1, a2;
    logic [3:0] i0;
    logic       b0;

    vt[0] = '{PT_C1, 1'b0, CT_C1};
    vt[1] = '{PT_B,  1'b1, CT_B};
    vt[2] = '{PT_B,  1'b1, CT_B};
    vt[3] = '{PT_C1, 1'b0, CT_C1};

    build_sbox();
    expand(0, KEY_C1);
    expand(1, KEY_B);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
`ifdef AES_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_rk_idx", 128'(rk_idx), 128'd0);
    chk("reset_ciphertext", ciphertext, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 vectors with out_ready held high
    for (int v = 0; v < 4; v++) begin
      send(vt[v].pt, vt[v].sel, vt[v].exp, a1, i0, b0);
      wait_out(i0, b0);
      drain();
    end

    // Backpressure: DONE holds with stable ciphertext, input pulses ignored
    out_ready = 1'b0;
    send(PT_B, 1'b1, CT_B, a1, i0, b0);
    wait_out(i0, b0);
    for (int k = 0; k < 20; k++) begin
      in_valid  = k[0];
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
      chk("bp_ciphertext", ciphertext, CT_B);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    chk("bp_delivered", 128'(exp_q.size()), 128'd0);

    // Back-to-back blocks with in_valid and out_ready held high
    send(PT_C1, 1'b0, CT_C1, a1, i0, b0);
    send(PT_B, 1'b1, CT_B, a2, i0, b0);
    chk("b2b_period", 128'(a2 - a1), 128'd12);
    drain();

    // Reset in the middle of round 5 discards the block
    send(PT_C1, 1'b0, CT_C1, a1, i0, b0);
    reach_round(4'd5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_idle("mid_reset");
    rst_n = 1'b1;
    no_output("no_out_after_reset");
    send(PT_B, 1'b1, CT_B, a1, i0, b0);
    wait_out(i0, b0);
    drain();

`ifdef AES_CTRL_ABORT_EN
    // Abort during round 3, then a clean C.1 block
    send(PT_C1, 1'b0, CT_C1, a1, i0, b0);
    reach_round(4'd3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    check_idle("abort_round");
    no_output("no_out_after_abort");
    send(PT_C1, 1'b0, CT_C1, a1, i0, b0);
    wait_out(i0, b0);
    drain();

    // Abort in DONE beats a simultaneous out_ready; result register is kept
    out_ready = 1'b0;
    send(PT_B, 1'b1, CT_B, a1, i0, b0);
    wait_out(i0, b0);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    check_idle("abort_done");
    chk("abort_done_ciphertext", ciphertext, CT_B);
    no_output("no_out_after_done_abort");
`endif

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
